seg7_display_ctrl: RTL and testbench

Parametrised multi-digit 7-segment display controller for the DE10-Lite HEX0..HEX5 bank, and the successor to the single-digit combinational hex decoder. It accepts a binary value over a valid/ready handshake and renders it in hex, or in decimal via a sequential binary-to-BCD converter. Adds leading-zero blanking, per-digit decimal points, per-digit blink and overflow indication. It sits between Nios PIO or fabric logic and the HEX pins.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_display_ctrl_if.sv | 23 ++
 rtl/bin2bcd_seq.sv | 66 ++++++
 rtl/seg7_display_ctrl.sv | 171 +++++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and glyph helpers for the multi-digit 7-segment controller.
// Glyphs are kept in active-low {dp,g,f,e,d,c,b,a} form throughout.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  function automatic logic [7:0] hex_font(input logic [3:0] value);
    logic [7:0] glyph;
    case (value)
      4'h0:    glyph = 8'hC0;
      4'h1:    glyph = 8'hF9;
      4'h2:    glyph = 8'hA4;
      4'h3:    glyph = 8'hB0;
      4'h4:    glyph = 8'h99;
      4'h5:    glyph = 8'h92;
      4'h6:    glyph = 8'h82;
      4'h7:    glyph = 8'hF8;
      4'h8:    glyph = 8'h80;
      4'h9:    glyph = 8'h90;
      4'hA:    glyph = 8'h88;
      4'hB:    glyph = 8'h83;
      4'hC:    glyph = 8'hC6;
      4'hD:    glyph = 8'hA1;
      4'hE:    glyph = 8'h86;
      default: glyph = 8'h8E;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Value handshake between the producer (Nios PIO or fabric) and the display controller.
interface seg7_display_ctrl_if #(
  parameter int DATA_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_mode;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    output in_ready
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one shift per cycle for DATA_W cycles, with a sticky
// flag for any set bit pushed out of the top BCD column.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] shift_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic              run_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // done marks the cycle whose clock edge performs the final shift
  assign done = run_q && (cnt_q == CNT_W'(DATA_W - 1));
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b0;
    end else if (start) begin
      shift_q <= bin;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
      shift_q <= shift_q << 1;
      ovf_q   <= ovf_q | bcd_adj[BCD_W-1];
      cnt_q   <= cnt_q + 1'b1;
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit 7-segment controller: hex or decimal rendering with leading-zero
// blanking, per-digit DP and blink, and overflow dashes.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 24,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  seg7_display_ctrl_if.slave      in_if,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    busy,
  output logic                    overflow,
  output logic [8*NUM_DIGITS-1:0] seg
);

  localparam int HEX_W = 4 * NUM_DIGITS;
  localparam int PAD_W = (DATA_W > HEX_W) ? DATA_W : HEX_W;
  localparam int PRE_W = $clog2(BLINK_DIV);
  localparam logic [7:0] UNLIT = (ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;

  state_t                  state;
  logic                    in_ready_q;
  logic                    busy_q;
  logic [DATA_W-1:0]       data_q;
  logic                    mode_q;
  logic [HEX_W-1:0]        digits_q;
  logic                    ovf_q;
  logic                    shown_q;
  logic [PRE_W-1:0]        pre_q;
  logic                    blink_phase_q;
  logic [8*NUM_DIGITS-1:0] seg_q;
  logic [8*NUM_DIGITS-1:0] seg_next;
  logic [NUM_DIGITS-1:0]   lz_blank;

  logic             accept;
  logic             conv_done;
  logic [HEX_W-1:0] conv_bcd;
  logic             conv_ovf;
  logic [PAD_W-1:0] data_pad;
  logic [HEX_W-1:0] hex_digits;
  logic             hex_ovf;

  assign accept         = in_if.in_valid && in_ready_q;
  assign in_if.in_ready = in_ready_q;
  assign busy           = busy_q;
  assign overflow       = ovf_q;
  assign seg            = seg_q;

  // Zero-extend so bits beyond the display width can be tested for overflow
  assign data_pad   = PAD_W'(data_q);
  assign hex_digits = data_pad[HEX_W-1:0];
  assign hex_ovf    = |(data_pad >> HEX_W);

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (accept && in_if.in_mode),
    .bin   (in_if.in_data),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      data_q     <= '0;
      mode_q     <= 1'b0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
      shown_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q     <= in_if.in_data;
            mode_q     <= in_if.in_mode;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= in_if.in_mode ? CONV : LOAD;
          end
        end
        CONV: begin
          if (conv_done) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          digits_q   <= mode_q ? conv_bcd : hex_digits;
          ovf_q      <= mode_q ? conv_ovf : hex_ovf;
          shown_q    <= 1'b1;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q         <= '0;
      blink_phase_q <= 1'b0;
    end else if (pre_q == PRE_W'(BLINK_DIV - 1)) begin
      pre_q         <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // A digit is leading-zero blank when it and everything above it is zero; digit 0 never is
  always_comb begin
    logic any_nz;
    any_nz   = 1'b0;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      any_nz      = any_nz | (digits_q[4*i +: 4] != 4'd0);
      lz_blank[i] = blank_lz && !any_nz && (i != 0);
    end
  end

  always_comb begin
    logic [7:0] glyph;
    glyph    = SEG_BLANK;
    seg_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!shown_q) begin
        glyph = SEG_BLANK;
      end else begin
        if (ovf_q) begin
          glyph = SEG_DASH;
        end else if (lz_blank[i]) begin
          glyph = SEG_BLANK;
        end else begin
          glyph = hex_font(digits_q[4*i +: 4]);
        end
        if (dp_mask[i]) begin
          glyph[7] = 1'b0;
        end
        if (blink_phase_q && blink_mask[i]) begin
          glyph = SEG_BLANK;
        end
      end
      seg_next[8*i +: 8] = (ACTIVE_LOW != 0) ? glyph : ~glyph;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= {NUM_DIGITS{UNLIT}};
    end else begin
      seg_q <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Scoreboard bench for seg7_display_ctrl: expected glyphs are queued at issue
// and compared by a monitor one cycle after each commit (busy falling).
module tb_seg7_display_ctrl;

  localparam int ND = 6;
  localparam int DW = 24;

  typedef struct {
    logic [8*ND-1:0] seg;
    logic            ovf;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            blank_lz;
  logic [ND-1:0]   dp_mask;
  logic [ND-1:0]   blink_mask;
  logic            busy;
  logic            overflow;
  logic [8*ND-1:0] seg;

  int   total = 0;
  int   bad   = 0;
  int   edges_since_reset = 0;
  exp_t sb_q[$];

  seg7_display_ctrl_if #(.DATA_W(DW)) in_if ();

  seg7_display_ctrl #(
    .NUM_DIGITS (ND),
    .DATA_W     (DW),
    .BLINK_DIV  (4),
    .ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (in_if.slave),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .busy       (busy),
    .overflow   (overflow),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  // Reference for the blink prescaler: counts clock edges since reset release
  always @(posedge clk or posedge reset) begin
    if (reset) edges_since_reset = 0;
    else       edges_since_reset = edges_since_reset + 1;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [DW-1:0] data, input logic mode,
                                input logic [8*ND-1:0] exp_seg, input logic exp_ovf,
                                input int exp_busy, input bit inject);
    int wait_cnt;
    int busy_cnt;
    int nready_cnt;
    exp_t item;
    @(negedge clk);
    wait_cnt = 0;
    while (!in_if.in_ready && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!in_if.in_ready) begin
      check_output("ready_timeout", 64'd0, 64'd1);
      return;
    end
    item.seg = exp_seg;
    item.ovf = exp_ovf;
    sb_q.push_back(item);
    in_if.in_data  = data;
    in_if.in_mode  = mode;
    in_if.in_valid = 1'b1;
    @(posedge clk);
    #1 in_if.in_valid = 1'b0;
    busy_cnt   = 0;
    nready_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
      if (!in_if.in_ready) nready_cnt++;
      if (inject && c == 3) begin
        in_if.in_data  = 24'd999;
        in_if.in_mode  = 1'b0;
        in_if.in_valid = 1'b1;
      end
      if (inject && c == 8) in_if.in_valid = 1'b0;
    end
    in_if.in_valid = 1'b0;
    check_output("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    check_output("ready_low_cycles", 64'(nready_cnt), 64'(exp_busy));
    repeat (2) @(negedge clk);
  endtask

  // Monitor: a busy 1->0 transition is a commit; seg settles one cycle later
  initial begin
    logic prev_busy;
    exp_t item;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !busy) begin
          @(negedge clk);
          if (sb_q.size() == 0) begin
            check_output("unexpected_commit", 64'd1, 64'd0);
          end else begin
            item = sb_q.pop_front();
            check_output("seg", 64'(seg), 64'(item.seg));
            check_output("overflow", 64'(overflow), 64'(item.ovf));
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    logic [7:0] exp_hex0;
    int         n;
    reset          = 1'b1;
    blank_lz       = 1'b0;
    dp_mask        = '0;
    blink_mask     = '0;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    in_if.in_mode  = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_seg", 64'(seg), 64'hFFFF_FFFF_FFFF);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_overflow", 64'(overflow), 64'd0);
    check_output("rst_in_ready", 64'(in_if.in_ready), 64'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_output("pre_commit_unlit", 64'(seg), 64'hFFFF_FFFF_FFFF);

    apply_stimulus(24'h00ABCD, 1'b0, 48'hC0C0_8883_C6A1, 1'b0, 1, 1'b0);
    apply_stimulus(24'd123456, 1'b1, 48'hF9A4_B099_9282, 1'b0, 25, 1'b1);
    apply_stimulus(24'd1000000, 1'b1, 48'hBFBF_BFBF_BFBF, 1'b1, 25, 1'b0);
    apply_stimulus(24'h000001, 1'b0, 48'hC0C0_C0C0_C0F9, 1'b0, 1, 1'b0);

    blank_lz = 1'b1;
    apply_stimulus(24'h000042, 1'b0, 48'hFFFF_FFFF_99A4, 1'b0, 1, 1'b0);
    apply_stimulus(24'h000000, 1'b0, 48'hFFFF_FFFF_FFC0, 1'b0, 1, 1'b0);

    blank_lz = 1'b0;
    apply_stimulus(24'h000002, 1'b0, 48'hC0C0_C0C0_C0A4, 1'b0, 1, 1'b0);
    dp_mask    = 6'b000001;
    blink_mask = 6'b000001;
    @(negedge clk);
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      n = edges_since_reset;
      exp_hex0 = (((n - 1) / 4) % 2 == 0) ? 8'h24 : 8'hFF;
      check_output("blink_hex0", 64'(seg[7:0]), 64'(exp_hex0));
      check_output("blink_upper", 64'(seg[47:8]), 64'hC0_C0C0_C0C0);
    end
    dp_mask    = '0;
    blink_mask = '0;

    @(negedge clk);
    in_if.in_data  = 24'd654321;
    in_if.in_mode  = 1'b1;
    in_if.in_valid = 1'b1;
    @(posedge clk);
    #1 in_if.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check_output("midconv_seg", 64'(seg), 64'hFFFF_FFFF_FFFF);
    check_output("midconv_busy", 64'(busy), 64'd0);
    check_output("midconv_in_ready", 64'(in_if.in_ready), 64'd1);
    check_output("midconv_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    blank_lz = 1'b1;
    apply_stimulus(24'h000007, 1'b0, 48'hFFFF_FFFF_FFF8, 1'b0, 1, 1'b0);

    repeat (5) @(negedge clk);
    check_output("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
